// File: rtl/decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// decode_stage_pkg
// Shared definitions for the decode stage: ALU and branch control codes,
// RV32 opcode / funct constants, the skid-buffer state encoding and the
// decoded control bundle carried through the skid buffer.
// Related build macro: DECODE_ILLEGAL_EN (consumed by decode_core).
// -----------------------------------------------------------------------------
package decode_stage_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd3
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NO_JUMP = 3'd0,
        BR_BEQ     = 3'd1,
        BR_BLT     = 3'd2,
        BR_JAL     = 3'd3
    } branch_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BLT = 3'b100;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        alu_op_e    alu;
        branch_e    branch;
        logic       reg_we;
        logic       mem_we;
        logic       mem_re;
        logic       reg_sel;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{
        rs1:     5'd0,
        rs2:     5'd0,
        rd:      5'd0,
        alu:     ALU_AND,
        branch:  BR_NO_JUMP,
        reg_we:  1'b0,
        mem_we:  1'b0,
        mem_re:  1'b0,
        reg_sel: 1'b0,
        illegal: 1'b0
    };

endpackage

// File: rtl/decode_core.sv
// -----------------------------------------------------------------------------
// decode_core
// Purely combinational instruction decoder: 32-bit instruction in, control
// bundle plus sign-extended immediate out.
//   insn  in   32    raw instruction word
//   ctrl  out  ctrl_t register fields, ALU/branch codes, enables, illegal
//   imm   out  XLEN  I/S/B/U/J immediate, sign-extended (0 for R-type)
// Build macro DECODE_ILLEGAL_EN: when defined, unmatched encodings raise
// ctrl.illegal; otherwise illegal is constant 0.
// -----------------------------------------------------------------------------
module decode_core
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     insn,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm
);

`ifdef DECODE_ILLEGAL_EN
    localparam logic ILLEGAL_FLAG = TRUE;
`else
    localparam logic ILLEGAL_FLAG = FALSE;
`endif

    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [31:0] imm_j;
    logic signed [31:0] imm_sel;

    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    assign imm_i = {{20{insn[31]}}, insn[31:20]};
    assign imm_s = {{20{insn[31]}}, insn[31:25], insn[11:7]};
    assign imm_b = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    assign imm_u = {insn[31:12], 12'b0};
    assign imm_j = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

    always_comb begin
        ctrl     = CTRL_RESET;
        ctrl.rs1 = insn[19:15];
        ctrl.rs2 = insn[24:20];
        ctrl.rd  = insn[11:7];
        imm_sel  = '0;
        // Match key is {funct7, funct3, opcode}; funct7 only matters for R-type.
        casez ({insn[31:25], insn[14:12], insn[6:0]})
            {7'b???????, F3_LW, OPC_LOAD}: begin
                ctrl.reg_we = TRUE;
                ctrl.mem_re = TRUE;
                ctrl.alu    = ALU_ADD;
                imm_sel     = imm_i;
            end
            {7'b???????, F3_SW, OPC_STORE}: begin
                ctrl.mem_we = TRUE;
                ctrl.alu    = ALU_ADD;
                imm_sel     = imm_s;
            end
            {F7_BASE, F3_ADD, OPC_OP}: begin
                ctrl.reg_we  = TRUE;
                ctrl.reg_sel = TRUE;
                ctrl.alu     = ALU_ADD;
            end
            {F7_ALT, F3_ADD, OPC_OP}: begin
                ctrl.reg_we  = TRUE;
                ctrl.reg_sel = TRUE;
                ctrl.alu     = ALU_SUB;
            end
            {F7_BASE, F3_AND, OPC_OP}: begin
                ctrl.reg_we  = TRUE;
                ctrl.reg_sel = TRUE;
                ctrl.alu     = ALU_AND;
            end
            {F7_BASE, F3_OR, OPC_OP}: begin
                ctrl.reg_we  = TRUE;
                ctrl.reg_sel = TRUE;
                ctrl.alu     = ALU_OR;
            end
            {7'b???????, F3_ADD, OPC_OP_IMM}: begin
                ctrl.reg_we = TRUE;
                ctrl.alu    = ALU_ADD;
                imm_sel     = imm_i;
            end
            {7'b???????, F3_BEQ, OPC_BRANCH}: begin
                ctrl.alu    = ALU_SUB;
                ctrl.branch = BR_BEQ;
                imm_sel     = imm_b;
            end
            {7'b???????, F3_BLT, OPC_BRANCH}: begin
                ctrl.alu    = ALU_SUB;
                ctrl.branch = BR_BLT;
                imm_sel     = imm_b;
            end
            {7'b???????, 3'b???, OPC_LUI}: begin
                ctrl.reg_we = TRUE;
                ctrl.alu    = ALU_ADD;
                imm_sel     = imm_u;
            end
            {7'b???????, 3'b???, OPC_JAL}: begin
                ctrl.reg_we = TRUE;
                ctrl.alu    = ALU_ADD;
                ctrl.branch = BR_JAL;
                imm_sel     = imm_j;
            end
            default: begin
                ctrl.illegal = ILLEGAL_FLAG;
            end
        endcase
    end

    assign imm = sext32(imm_sel);

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Registered decode stage with a two-entry skid buffer (output register plus
// one skid entry). Decoding happens in decode_core on the incoming word; the
// decoded bundle is what gets buffered.
//   clk, rst_n        clock, synchronous active-low reset
//   flush             drop everything buffered (and any same-cycle accept)
//   in_valid/in_ready upstream handshake; in_ready is a flop
//   in_insn, in_pc    instruction word and its PC
//   out_valid/out_ready downstream handshake
//   rs1, rs2, rd, imm, alu_ctr, branch_ctr, reg_we, mem_we, mem_re,
//   reg_sel, illegal, out_pc  registered decode result
// Build macro DECODE_ILLEGAL_EN enables the illegal flag (see decode_core).
// -----------------------------------------------------------------------------
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ALU_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_insn,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [XLEN-1:0]  imm,
    output logic [ALU_W-1:0] alu_ctr,
    output logic [2:0]       branch_ctr,
    output logic             reg_we,
    output logic             mem_we,
    output logic             mem_re,
    output logic             reg_sel,
    output logic             illegal,
    output logic [XLEN-1:0]  out_pc
);

    ctrl_t           dec_ctrl;
    logic [XLEN-1:0] dec_imm;

    decode_core #(
        .XLEN(XLEN)
    ) u_decode_core (
        .insn(in_insn),
        .ctrl(dec_ctrl),
        .imm (dec_imm)
    );

    skid_state_e     state_q,     state_d;
    logic            in_ready_q,  in_ready_d;
    logic            out_valid_q, out_valid_d;
    ctrl_t           out_ctrl_q,  out_ctrl_d;
    logic [XLEN-1:0] out_imm_q,   out_imm_d;
    logic [XLEN-1:0] out_pc_q,    out_pc_d;
    ctrl_t           skid_ctrl_q, skid_ctrl_d;
    logic [XLEN-1:0] skid_imm_q,  skid_imm_d;
    logic [XLEN-1:0] skid_pc_q,   skid_pc_d;

    logic accept;
    logic pop;

    // Both handshakes use only flopped readiness/validity, so out_ready never
    // reaches in_ready combinationally.
    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        out_ctrl_d  = out_ctrl_q;
        out_imm_d   = out_imm_q;
        out_pc_d    = out_pc_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_imm_d  = skid_imm_q;
        skid_pc_d   = skid_pc_q;

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d    = ST_ONE;
                        out_ctrl_d = dec_ctrl;
                        out_imm_d  = dec_imm;
                        out_pc_d   = in_pc;
                    end
                end
                ST_ONE: begin
                    if (accept && !pop) begin
                        // Output is stalled: park the new word in the skid entry.
                        state_d     = ST_FULL;
                        skid_ctrl_d = dec_ctrl;
                        skid_imm_d  = dec_imm;
                        skid_pc_d   = in_pc;
                    end else if (accept && pop) begin
                        out_ctrl_d = dec_ctrl;
                        out_imm_d  = dec_imm;
                        out_pc_d   = in_pc;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        state_d    = ST_ONE;
                        out_ctrl_d = skid_ctrl_q;
                        out_imm_d  = skid_imm_q;
                        out_pc_d   = skid_pc_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= TRUE;
            out_valid_q <= FALSE;
            out_ctrl_q  <= CTRL_RESET;
            out_imm_q   <= '0;
            out_pc_q    <= '0;
            skid_ctrl_q <= CTRL_RESET;
            skid_imm_q  <= '0;
            skid_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_ctrl_q  <= out_ctrl_d;
            out_imm_q   <= out_imm_d;
            out_pc_q    <= out_pc_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_imm_q  <= skid_imm_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign rs1        = out_ctrl_q.rs1;
    assign rs2        = out_ctrl_q.rs2;
    assign rd         = out_ctrl_q.rd;
    assign imm        = out_imm_q;
    assign alu_ctr    = ALU_W'(out_ctrl_q.alu);
    assign branch_ctr = out_ctrl_q.branch;
    assign reg_we     = out_ctrl_q.reg_we;
    assign mem_we     = out_ctrl_q.mem_we;
    assign mem_re     = out_ctrl_q.mem_re;
    assign reg_sel    = out_ctrl_q.reg_sel;
    assign illegal    = out_ctrl_q.illegal;
    assign out_pc     = out_pc_q;

endmodule
